// File: rtl/ps2_pkg.sv
// Shared PS/2 types and defaults for the host transmitter and receiver.
// Cycle defaults assume a 50 MHz system clock.
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE,
    DONE
  } tx_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_NACK    = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_e;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_TIMEOUT_CYCLES = 750000;
  localparam int DEF_SYNC_STAGES    = 2;

  // Counter width for a count that runs 0 .. n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the raw PS/2 clock and data pads into the system clock domain
// and produces a one-cycle strobe on each synced clock falling edge.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_lvl_o,
  output logic data_lvl_o,
  output logic clk_fe_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;

  // Idle bus level is high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_lvl_o  = clk_sync_q[SYNC_STAGES-1];
  assign data_lvl_o = data_sync_q[SYNC_STAGES-1];
  assign clk_fe_o   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift
// data/parity/stop on device clock falling edges, check ACK, report errors.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic                  i_driver_clk,
  input  logic                  rst,
  input  logic                  i_ps2_clk,
  input  logic                  i_ps2_data,
  output logic                  o_ps2_clk_oe,
  output logic                  o_ps2_data_oe,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_byte,
  output logic                  o_done,
  output logic                  o_err,
  output logic [1:0]            o_err_code,
  output logic                  o_busy
);

  localparam int INH_W = cnt_width(INHIBIT_CYCLES);
  localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);
  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;

  logic clk_lvl, data_lvl, clk_fe;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (i_driver_clk),
    .rst_i      (rst),
    .ps2_clk_i  (i_ps2_clk),
    .ps2_data_i (i_ps2_data),
    .clk_lvl_o  (clk_lvl),
    .data_lvl_o (data_lvl),
    .clk_fe_o   (clk_fe)
  );

  tx_state_e             state_q, state_d;
  logic [INH_W-1:0]      inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] byte_q, byte_d;
  logic                  par_q, par_d;
  logic                  data_oe_q, data_oe_d;
  logic                  err_q, err_d;
  err_code_e             err_code_q, err_code_d;

  logic tmo_active, tmo_hit;

  assign tmo_active = state_q inside {REQ, SHIFT, PARITY, STOP, ACK, WAIT_IDLE};
  assign tmo_hit    = tmo_active && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_driver_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      inh_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      par_q      <= 1'b0;
      data_oe_q  <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      par_q      <= par_d;
      data_oe_q  <= data_oe_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    par_d      = par_q;
    data_oe_d  = data_oe_q;
    err_d      = err_q;
    err_code_d = err_code_q;

    if (tmo_active) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          byte_d     = i_byte;
          par_d      = ~^i_byte;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          inh_cnt_d  = '0;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + INH_W'(1);
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
          tmo_cnt_d = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        idx_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (clk_fe) begin
          data_oe_d = ~byte_q[idx_q[IDX_W-2:0]];
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) state_d = PARITY;
        end
      end
      PARITY: begin
        if (clk_fe) begin
          data_oe_d = ~par_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (clk_fe) begin
          data_oe_d = 1'b0;
          state_d   = ACK;
        end
      end
      ACK: begin
        if (clk_fe) begin
          if (!data_lvl) begin
            state_d = WAIT_IDLE;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_NACK;
            state_d    = DONE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_lvl && data_lvl) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A stalled device must not leave the bus held; this overrides any edge.
    if (tmo_hit) begin
      data_oe_d  = 1'b0;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = DONE;
    end
  end

  assign o_ps2_clk_oe  = state_q inside {INHIBIT, REQ};
  assign o_ps2_data_oe = data_oe_q;
  assign o_ready       = (state_q == IDLE);
  assign o_busy        = (state_q != IDLE);
  assign o_done        = (state_q == DONE);
  assign o_err         = err_q;
  assign o_err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device that
// clocks the frame, samples bits on rising edges and optionally ACKs.
module tb_ps2_host_tx;

  localparam int DW   = 8;
  localparam int INH  = 50;
  localparam int TMO  = 2000;
  localparam int SYNC = 2;
  localparam int HALF = 20;

  logic       clk, rst;
  logic       ps2_clk_line, ps2_data_line;
  logic       clk_oe, data_oe;
  logic       i_valid, o_ready, o_done, o_err, o_busy;
  logic [7:0] i_byte;
  logic [1:0] o_err_code;
  logic       dev_clk_low, dev_data_low;

  assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
  assign ps2_data_line = ~(data_oe | dev_data_low);

  ps2_host_tx #(
    .DATA_WIDTH(DW), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)
  ) dut (
    .i_driver_clk (clk),
    .rst          (rst),
    .i_ps2_clk    (ps2_clk_line),
    .i_ps2_data   (ps2_data_line),
    .o_ps2_clk_oe (clk_oe),
    .o_ps2_data_oe(data_oe),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_byte       (i_byte),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_err_code   (o_err_code),
    .o_busy       (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc_q[$];
  logic done_err_q[$];
  logic [1:0] done_code_q[$];
  logic [1:0] done_oe_q[$];
  int acc_cyc_q[$];
  logic clk_oe_prev = 1'b0;
  int req_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_done === 1'b1) begin
      done_cyc_q.push_back(cyc);
      done_err_q.push_back(o_err);
      done_code_q.push_back(o_err_code);
      done_oe_q.push_back({clk_oe, data_oe});
    end
    if (i_valid === 1'b1 && o_ready === 1'b1) acc_cyc_q.push_back(cyc);
    if (clk_oe_prev === 1'b1 && clk_oe === 1'b0) req_cyc = cyc - 1;
    clk_oe_prev = clk_oe;
  end

  // Line levels the device should see: data LSB first, odd parity, stop=1.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int k;
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_byte  = b;
    k = 0;
    do begin @(negedge clk); k++; end while (o_ready !== 1'b1 && k < 5000);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic send_two(input logic [7:0] b1, input logic [7:0] b2);
    int k;
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_byte  = b1;
    k = 0;
    do begin @(negedge clk); k++; end while (o_ready !== 1'b1 && k < 5000);
    @(posedge clk); #1;
    i_byte = b2;
    k = 0;
    do begin @(negedge clk); k++; end while (o_ready !== 1'b1 && k < 5000);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // Device: waits for the host inhibit, measures it, then generates pulses.
  task automatic dev_frame(input int pulses, input bit ack, output logic [9:0] bits,
                           output int inh_len, output bit start_ok);
    int n;
    bits     = '1;
    inh_len  = 0;
    start_ok = 1'b0;
    n = 0;
    while (clk_oe !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    while (clk_oe === 1'b1 && inh_len < 20000) begin @(negedge clk); inh_len++; end
    start_ok = (ps2_data_line === 1'b0);
    repeat (HALF) @(negedge clk);
    for (int p = 1; p <= pulses; p++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (p <= 10) bits[p-1] = ps2_data_line;
      if (p == 10 && ack) dev_data_low = 1'b1;
      if (p == 11) dev_data_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int n_exp, input int limit);
    int k;
    k = 0;
    while (done_cyc_q.size() < n_exp && k < limit) begin @(negedge clk); k++; end
    @(negedge clk);
    chk("done_count", 32'(done_cyc_q.size()), 32'(n_exp));
  endtask

  logic [9:0] bits_a, bits_b;
  int         inh_a, inh_b;
  bit         start_a, start_b;
  int         n0, a0;
  logic [7:0] rb;
  logic       busy_seen;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_byte = '0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_clk_oe", 32'(clk_oe), 32'd0);
    chk("rst_data_oe", 32'(data_oe), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_code", 32'(o_err_code), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);

    // 0xF4 with ACK
    n0 = done_cyc_q.size();
    fork
      send(8'hF4);
      dev_frame(11, 1'b1, bits_a, inh_a, start_a);
    join
    wait_done(n0 + 1, 3000);
    chk("f4_inhibit_ge", 32'(inh_a >= INH), 32'd1);
    chk("f4_start_low", 32'(start_a), 32'd1);
    chk("f4_bits", 32'(bits_a), 32'(exp_frame(8'hF4)));
    chk("f4_err", 32'(done_err_q[$]), 32'd0);
    chk("f4_code", 32'(done_code_q[$]), 32'd0);

    // 0xFF then 0x00, i_valid held
    repeat (20) @(posedge clk);
    n0 = done_cyc_q.size();
    a0 = acc_cyc_q.size();
    fork
      send_two(8'hFF, 8'h00);
      begin
        dev_frame(11, 1'b1, bits_a, inh_a, start_a);
        dev_frame(11, 1'b1, bits_b, inh_b, start_b);
      end
    join
    wait_done(n0 + 2, 3000);
    chk("ff_bits", 32'(bits_a), 32'(exp_frame(8'hFF)));
    chk("ff_parity", 32'(bits_a[8]), 32'd1);
    chk("00_bits", 32'(bits_b), 32'(exp_frame(8'h00)));
    chk("00_parity", 32'(bits_b[8]), 32'd1);
    chk("b2b_accepts", 32'(acc_cyc_q.size() - a0), 32'd2);
    chk("b2b_second_after_done", 32'(acc_cyc_q[a0+1] > done_cyc_q[n0]), 32'd1);

    // NACK: data left high at the ACK clock
    repeat (20) @(posedge clk);
    n0 = done_cyc_q.size();
    fork
      send(8'h3A);
      dev_frame(11, 1'b0, bits_a, inh_a, start_a);
    join
    wait_done(n0 + 1, 3000);
    chk("nack_bits", 32'(bits_a), 32'(exp_frame(8'h3A)));
    chk("nack_err", 32'(done_err_q[$]), 32'd1);
    chk("nack_code", 32'(done_code_q[$]), 32'd1);
    chk("nack_oe", 32'(done_oe_q[$]), 32'd0);

    // Timeout: device never clocks
    repeat (20) @(posedge clk);
    n0 = done_cyc_q.size();
    fork
      send(8'h3C);
      dev_frame(0, 1'b1, bits_a, inh_a, start_a);
    join
    wait_done(n0 + 1, TMO + 500);
    chk("tmo_err", 32'(done_err_q[$]), 32'd1);
    chk("tmo_code", 32'(done_code_q[$]), 32'd2);
    chk("tmo_oe", 32'(done_oe_q[$]), 32'd0);
    chk("tmo_latency", 32'(done_cyc_q[$] - req_cyc), 32'(TMO));

    // Reset mid-frame while bit 3 of 0x00 drives the line low
    repeat (20) @(posedge clk);
    n0 = done_cyc_q.size();
    fork
      send(8'h00);
      dev_frame(4, 1'b0, bits_a, inh_a, start_a);
    join
    chk("abort_pre_data_oe", 32'(data_oe), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("abort_clk_oe", 32'(clk_oe), 32'd0);
    chk("abort_data_oe", 32'(data_oe), 32'd0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(o_ready), 32'd1);
    repeat (200) @(negedge clk);
    chk("abort_no_done", 32'(done_cyc_q.size()), 32'(n0));

    n0 = done_cyc_q.size();
    fork
      send(8'hAA);
      dev_frame(11, 1'b1, bits_a, inh_a, start_a);
    join
    wait_done(n0 + 1, 3000);
    chk("aa_bits", 32'(bits_a), 32'(exp_frame(8'hAA)));
    chk("aa_err", 32'(done_err_q[$]), 32'd0);

    // i_valid pulse with 0x55 while busy is ignored
    repeat (20) @(posedge clk);
    rb = 8'($urandom_range(255));
    if (rb == 8'h55) rb = 8'hA5;
    n0 = done_cyc_q.size();
    a0 = acc_cyc_q.size();
    busy_seen = 1'b0;
    fork
      send(rb);
      dev_frame(11, 1'b1, bits_a, inh_a, start_a);
      begin
        repeat (200) @(posedge clk); #1;
        busy_seen = o_busy;
        i_valid = 1'b1;
        i_byte  = 8'h55;
        @(posedge clk); #1;
        i_valid = 1'b0;
      end
    join
    wait_done(n0 + 1, 3000);
    chk("ign_busy", 32'(busy_seen), 32'd1);
    chk("ign_bits", 32'(bits_a), 32'(exp_frame(rb)));
    chk("ign_accepts", 32'(acc_cyc_q.size() - a0), 32'd1);

    // Random bytes
    for (int t = 0; t < 4; t++) begin
      repeat (20) @(posedge clk);
      rb = 8'($urandom_range(255));
      n0 = done_cyc_q.size();
      fork
        send(rb);
        dev_frame(11, 1'b1, bits_a, inh_a, start_a);
      join
      wait_done(n0 + 1, 3000);
      chk("rnd_bits", 32'(bits_a), 32'(exp_frame(rb)));
      chk("rnd_err", 32'(done_err_q[$]), 32'd0);
    end

    repeat (10) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Parametrised PS/2 host-to-device transmitter: sends one command frame (start, DATA_WIDTH data bits LSB-first, odd parity, stop) and checks the device ACK.
- Runs on the system clock. PS/2 lines are synchronised and edge-detected internally; they are not used as clocks.
- Adds inhibit timing, a transaction timeout, ACK checking and error reporting.
- Sits between the mouse init/command controller and the top-level open-drain pads.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- INHIBIT_CYCLES, 5000, system cycles PS/2 clk is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, maximum cycles from clk release to end of ACK/idle (15 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop depth of the line synchronisers (minimum 2).

Ports:
- i_driver_clk  in  1  system clock.
- rst  in  1  reset: one clock domain, asynchronous, active-high.
- i_ps2_clk  in  1  raw PS/2 clock pad level.
- i_ps2_data  in  1  raw PS/2 data pad level.
- o_ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release.
- o_ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release.
- i_valid  in  1  byte request.
- o_ready  out  1  idle, request accepted.
- i_byte  in  DATA_WIDTH  byte to send.
- o_done  out  1  one-cycle pulse at end of transaction.
- o_err  out  1  qualified by o_done: 1 = failed.
- o_err_code  out  2  qualified by o_done: 0 none, 1 no ACK, 2 timeout.
- o_busy  out  1  transaction in progress (receiver must ignore the bus).

Behaviour:
- Reset values: both *_oe=0, o_ready=1, o_done=0, o_err=0, o_err_code=0, o_busy=0. FSM goes to IDLE and all counters clear.
- Reset asserted mid-frame releases both lines immediately. No o_done is issued.
- Line inputs pass through SYNC_STAGES flops. A falling edge (fe) is a synced level of 1 then 0 on consecutive cycles.
- Handshake: a request is accepted on the cycle where i_valid && o_ready. i_byte is latched and odd parity is computed then (parity = ~^byte). o_ready drops the next cycle. i_valid while busy is ignored.
- States and transitions:
  - IDLE: o_ready=1. On accept, go to INHIBIT.
  - INHIBIT: clk_oe=1, counter runs INHIBIT_CYCLES. Then go to REQ.
  - REQ: data_oe=1 (start bit 0). Held 1 cycle with clk_oe=1, then clk_oe=0. Timeout counter starts. Go to SHIFT with bit index 0.
  - SHIFT: on each fe, present bit[idx] (data_oe = ~bit) and increment idx. After the fe that presents bit DATA_WIDTH-1, go to PARITY.
  - PARITY: on fe, data_oe = ~parity. Go to STOP.
  - STOP: on fe, data_oe=0 (release; stop bit = 1). Go to ACK.
  - ACK: on fe, sample synced data. 0 gives ACK and goes to WAIT_IDLE. 1 sets error code 1 and goes to DONE.
  - WAIT_IDLE: wait until synced clk and data are both 1, then go to DONE.
  - DONE: o_done=1 for one cycle with error fields valid. Return to IDLE; o_ready=1 the following cycle.
- Timeout: active from REQ through WAIT_IDLE. When the counter reaches TIMEOUT_CYCLES-1, release both lines, set error code 2 and go to DONE. Timeout takes priority over a fe in the same cycle.
- o_busy = state != IDLE.
- Error fields hold their value until the next accept. They are cleared on accept.
- Data changes only in the cycle after a detected fe; it is never changed on a rising edge.
- Counter widths are $clog2 of the respective parameter. The bit index is $clog2(DATA_WIDTH)+1 wide.
- Glitch rejection is not required beyond the synchroniser.

Decomposition:
- Shared package (ps2_pkg):
  - typedef enum for the tx state: IDLE, INHIBIT, REQ, SHIFT, PARITY, STOP, ACK, WAIT_IDLE, DONE.
  - Error code enum: ERR_NONE, ERR_NACK, ERR_TIMEOUT.
  - Default cycle constants.
  - The same package is reused by the receiver.
- One sub-module: ps2_line_sync. It synchronises both lines and outputs levels plus a clk falling-edge strobe. It is shared with the receiver.

Test Plan:
- Send 0xF4. The device model clocks at 12.5 kHz and ACKs. Check:
  - data bits 0,0,1,0,1,1,1,1 and parity 0 sampled on device rising edges;
  - o_done pulse with o_err=0;
  - clk held low ≥5000 cycles before release.
- Send 0xFF then 0x00 back-to-back, with i_valid held across o_ready. Expect parity 1 for both, exactly two o_done pulses, second accept only after the first o_done.
- Device leaves data high at the ACK clock. Expect o_done with o_err=1, o_err_code=1, both oe=0.
- Device never clocks after release. Expect o_done at TIMEOUT_CYCLES after REQ with o_err_code=2 and both lines released.
- Assert rst during SHIFT bit 3. Expect both oe=0 asynchronously, o_ready=1 after release, no o_done. The next send of 0xAA completes normally.
- Pulse i_valid while o_busy=1 with i_byte=0x55. Expect it ignored and the in-flight byte transmitted unchanged.
